sevenseg_capture: RTL
=====================

Name: sevenseg_capture

Overview:
- Receiving end of the multiplexed seven-segment interface: samples the 12-bit `{digit-select, segments}` bus that the display driver emits.
- Rebuilds the full per-digit segment frame: one byte per cell, packed the same way as the driver's `cellvalin`.
- Used for board-to-board display snooping and as a self-check monitor on the driver output.
- Input is treated as asynchronous to `clock`.

Parameters:
- NUMCELLS, 4, number of digits; select field width.
- SETTLE, 8, consecutive identical synchronized samples required before a digit is accepted (≥2).
- TIMEOUT_W, 16, width of the inactivity counter; loss of lock after 2^TIMEOUT_W cycles without a capture.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- sig  input  NUMCELLS+8  `{sel[NUMCELLS-1:0], seg[7:0]}`; seg bit0=A … bit7=DP; sel bit k = DIG(k+1)
- cellvalout  output  8*NUMCELLS  last complete frame; byte j at bits [8j+7:8j]
- frame_valid  output  1  one-cycle pulse when cellvalout updates
- locked  output  1  high after the first complete frame until timeout or reset
- sel_err  output  1  one-cycle pulse when a settled sample has a non-one-hot sel

Behaviour:
- Reset (async assert, sync release):
  - cellvalout=0, frame_valid=0, locked=0, sel_err=0.
  - Shadow buffer=0, captured mask=0, settle count=0, timeout count=0, state=SETTLING.
- Input path:
  - 2-flop synchronizer on all sig bits; `s` = synchronized value.
  - Latency sig→s is 2 cycles.
- Stability counter:
  - `s_prev` registered each cycle.
  - If s != s_prev: count←0 and state←SETTLING.
  - Otherwise count increments, saturating at SETTLE-1.
- Mapping: select bit k carries byte NUMCELLS-1-k. DIG1 (bit0) carries the most-significant byte, matching the driver's rotation order.
- State SETTLING:
  - On the cycle count reaches SETTLE-1 with s unchanged, go to HOLD.
  - If sel is one-hot: write seg into shadow byte NUMCELLS-1-k and set mask bit k.
  - If sel is zero or multi-hot: write nothing and pulse sel_err.
- State HOLD:
  - No further writes for the same dwell.
  - Any change in s returns to SETTLING (count←0).
- Frame completion:
  - On the cycle the write makes mask all-ones, and in the same cycle: cellvalout←shadow including the just-written byte, frame_valid=1 (next cycle 0), mask←0, locked←1.
  - cellvalout updates 2 cycles after completion-point sync latency + SETTLE.
- Repeat digit: a second capture of a digit already in the mask before completion overwrites its shadow byte; the mask is unchanged.
- Timeout:
  - Counter clears on every successful capture and increments otherwise.
  - At terminal value 2^TIMEOUT_W-1: locked←0, mask←0, counter←0 and restarts.
  - cellvalout holds its last value.
- Simultaneous events: a capture on the terminal-count cycle wins (counter clears, no unlock).
- Reset mid-frame discards the partial frame.
- All-blank digits (seg=0) are valid captures.

Optional Feature:
- Macro: SEVENSEG_CAPTURE_ACTIVE_LOW_EN.
- Defined: the synchronized sig is inverted bitwise before all logic, for common-anode wiring (low select, low segment = on). Stored bytes and cellvalout are in active-high form. Reset value of cellvalout is still 0.
- Undefined: sig is interpreted active-high, as the driver produces it.

Decomposition:
- Package sevenseg_pkg:
  - SEG_W=8 and segment bit indices SEG_A..SEG_DP.
  - Capture state enum {SETTLING, HOLD}.
  - Glyph constants GLYPH_0..GLYPH_9 (0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F) for the bench.
- Sub-module sevenseg_sync: parameterized-width 2-flop synchronizer with async active-low reset to 0.

Test Plan:
- Driver model: cellvalin=32'h3F065B4F, dwell 1024 cycles, sel order 0001→0010→0100→1000 carrying 3F,06,5B,4F → after fourth settled dwell cellvalout=32'h3F065B4F, one frame_valid pulse, locked=1.
- Glitch: sig held 0x13F, then for SETTLE-2 cycles 0x106, then back to 0x13F → no capture of 06, no sel_err; after SETTLE cycles slot 3 = 3F.
- sel=4'b0110 held 50 cycles → exactly one sel_err pulse, mask unchanged, no frame_valid.
- Lock then stop toggling: sig constant after frame, TIMEOUT_W=6 → locked falls after 64 capture-free cycles, cellvalout retained.
- reset_n low after three digits captured, then the fourth digit arrives → no frame_valid until a full new 4-digit sequence is captured.
- With SEVENSEG_CAPTURE_ACTIVE_LOW_EN: driver output inverted on the wire, same values as the first scenario → cellvalout=32'h3F065B4F.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg
// Shared definitions for the seven-segment capture block: segment field
// width and bit positions, the capture state encoding, and the standard
// digit glyphs in the driver's segment packing (bit0=A ... bit7=DP).
package sevenseg_pkg;

  localparam int SEG_W  = 8;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef enum logic [0:0] {
    SETTLING = 1'b0,
    HOLD     = 1'b1
  } cap_state_e;

  localparam logic [SEG_W-1:0] GLYPH_0 = 8'h3F;
  localparam logic [SEG_W-1:0] GLYPH_1 = 8'h06;
  localparam logic [SEG_W-1:0] GLYPH_2 = 8'h5B;
  localparam logic [SEG_W-1:0] GLYPH_3 = 8'h4F;
  localparam logic [SEG_W-1:0] GLYPH_4 = 8'h66;
  localparam logic [SEG_W-1:0] GLYPH_5 = 8'h6D;
  localparam logic [SEG_W-1:0] GLYPH_6 = 8'h7D;
  localparam logic [SEG_W-1:0] GLYPH_7 = 8'h07;
  localparam logic [SEG_W-1:0] GLYPH_8 = 8'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9 = 8'h6F;

endpackage

// File: rtl/sevenseg_sync.sv
// sevenseg_sync
// Parameterized-width two-flop synchronizer, asynchronously cleared to 0.
// Ports:
//   clock   - destination clock
//   reset_n - asynchronous active-low reset
//   d       - asynchronous input bus
//   q       - synchronized output (two clock latency)
module sevenseg_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d;
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_d;
  logic [WIDTH-1:0] sync_q;

  // Next-state for the two synchronizer stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= {WIDTH{1'b0}};
      sync_q <= {WIDTH{1'b0}};
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sevenseg_capture.sv
// sevenseg_capture
// Receiver for a multiplexed seven-segment bus {sel, seg}. Each digit dwell
// must hold stable for SETTLE synchronized samples before its segment byte
// is written into a shadow frame; once every select line has been seen the
// whole frame is published on cellvalout with a one-cycle frame_valid.
// Select bit k lands in byte NUMCELLS-1-k (DIG1 carries the top byte).
//
// Ports:
//   clock       - system clock
//   reset_n     - asynchronous active-low reset
//   sig         - {sel[NUMCELLS-1:0], seg[7:0]}, asynchronous to clock
//   cellvalout  - last complete frame, byte j at [8j+7:8j]
//   frame_valid - one-cycle pulse when cellvalout updates
//   locked      - set by a complete frame, cleared by inactivity timeout
//   sel_err     - one-cycle pulse when a settled sample has non-one-hot sel
//
// Build option: SEVENSEG_CAPTURE_ACTIVE_LOW_EN inverts the synchronized bus
// (common-anode wiring); stored bytes stay active-high.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int NUMCELLS  = 4,
  parameter int SETTLE    = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUMCELLS+SEG_W-1:0] sig,
  output logic [SEG_W*NUMCELLS-1:0] cellvalout,
  output logic                      frame_valid,
  output logic                      locked,
  output logic                      sel_err
);

  localparam int W  = NUMCELLS + SEG_W;
  localparam int FW = SEG_W * NUMCELLS;
  localparam int CW = $clog2(SETTLE);

  localparam logic [CW-1:0]        CNT_MAX   = CW'(SETTLE - 1);
  localparam logic [CW-1:0]        CNT_CAP   = CW'(SETTLE - 2);
  localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
  localparam logic [TIMEOUT_W-1:0] TO_MAX    = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] TO_ONE    = TIMEOUT_W'(1);
  localparam logic [NUMCELLS-1:0]  MASK_FULL = {NUMCELLS{1'b1}};
  localparam logic [NUMCELLS-1:0]  SEL_ONE   = NUMCELLS'(1);

  logic                 rst_n_s;
  logic [W-1:0]         sig_sync_s;
  logic [W-1:0]         s_s;
  logic [NUMCELLS-1:0]  sel_s;
  logic [SEG_W-1:0]     seg_s;
  logic                 stable_s;
  logic                 onehot_s;
  logic [FW-1:0]        shadow_wr_s;
  logic [NUMCELLS-1:0]  mask_wr_s;

  logic [W-1:0]         s_prev_d,      s_prev_q;
  logic [CW-1:0]        count_d,       count_q;
  cap_state_e           state_d,       state_q;
  logic [FW-1:0]        shadow_d,      shadow_q;
  logic [NUMCELLS-1:0]  mask_d,        mask_q;
  logic [TIMEOUT_W-1:0] to_d,          to_q;
  logic [FW-1:0]        cellval_d,     cellval_q;
  logic                 frame_valid_d, frame_valid_q;
  logic                 locked_d,      locked_q;
  logic                 sel_err_d,     sel_err_q;

  // Reset release is resynchronized so all capture state leaves reset on
  // the same edge; assertion remains asynchronous.
  sevenseg_sync #(.WIDTH(1)) u_rst_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (1'b1),
    .q       (rst_n_s)
  );

  sevenseg_sync #(.WIDTH(W)) u_sig_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (sig),
    .q       (sig_sync_s)
  );

`ifdef SEVENSEG_CAPTURE_ACTIVE_LOW_EN
  assign s_s = ~sig_sync_s;
`else
  assign s_s = sig_sync_s;
`endif

  assign sel_s    = s_s[W-1:SEG_W];
  assign seg_s    = s_s[SEG_W-1:0];
  assign stable_s = (s_s == s_prev_q);
  // x & (x-1) clears the lowest set bit: zero result means at most one bit.
  assign onehot_s = (sel_s != {NUMCELLS{1'b0}}) &&
                    ((sel_s & (sel_s - SEL_ONE)) == {NUMCELLS{1'b0}});

  // Shadow frame and mask as they would look after writing the current sample.
  always_comb begin
    shadow_wr_s = shadow_q;
    mask_wr_s   = mask_q;
    for (int k = 0; k < NUMCELLS; k++) begin
      if (sel_s[k]) begin
        shadow_wr_s[SEG_W*(NUMCELLS-1-k) +: SEG_W] = seg_s;
        mask_wr_s[k] = 1'b1;
      end else begin
        mask_wr_s[k] = mask_q[k];
      end
    end
  end

  // Stability tracking, capture decision, frame assembly and timeout.
  always_comb begin
    logic write_v;
    write_v       = 1'b0;
    s_prev_d      = s_s;
    count_d       = count_q;
    state_d       = state_q;
    shadow_d      = shadow_q;
    mask_d        = mask_q;
    to_d          = to_q;
    cellval_d     = cellval_q;
    frame_valid_d = 1'b0;
    locked_d      = locked_q;
    sel_err_d     = 1'b0;

    if (!stable_s) begin
      count_d = {CW{1'b0}};
      state_d = SETTLING;
    end else begin
      if (count_q != CNT_MAX) begin
        count_d = count_q + CNT_ONE;
      end else begin
        count_d = count_q;
      end
      case (state_q)
        SETTLING: begin
          // This sample makes SETTLE identical samples in a row.
          if (count_q == CNT_CAP) begin
            state_d = HOLD;
            if (onehot_s) begin
              write_v = 1'b1;
            end else begin
              sel_err_d = 1'b1;
            end
          end else begin
            state_d = SETTLING;
          end
        end
        HOLD:    state_d = HOLD;
        default: state_d = SETTLING;
      endcase
    end

    if (write_v) begin
      to_d     = {TIMEOUT_W{1'b0}};
      shadow_d = shadow_wr_s;
      if (mask_wr_s == MASK_FULL) begin
        cellval_d     = shadow_wr_s;
        frame_valid_d = 1'b1;
        mask_d        = {NUMCELLS{1'b0}};
        locked_d      = 1'b1;
      end else begin
        mask_d = mask_wr_s;
      end
    end else begin
      if (to_q == TO_MAX) begin
        locked_d = 1'b0;
        mask_d   = {NUMCELLS{1'b0}};
        to_d     = {TIMEOUT_W{1'b0}};
      end else begin
        to_d = to_q + TO_ONE;
      end
    end
  end

  // Capture state and registered outputs.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      s_prev_q      <= {W{1'b0}};
      count_q       <= {CW{1'b0}};
      state_q       <= SETTLING;
      shadow_q      <= {FW{1'b0}};
      mask_q        <= {NUMCELLS{1'b0}};
      to_q          <= {TIMEOUT_W{1'b0}};
      cellval_q     <= {FW{1'b0}};
      frame_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      s_prev_q      <= s_prev_d;
      count_q       <= count_d;
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      mask_q        <= mask_d;
      to_q          <= to_d;
      cellval_q     <= cellval_d;
      frame_valid_q <= frame_valid_d;
      locked_q      <= locked_d;
      sel_err_q     <= sel_err_d;
    end
  end

  assign cellvalout  = cellval_q;
  assign frame_valid = frame_valid_q;
  assign locked      = locked_q;
  assign sel_err     = sel_err_q;

endmodule
